// File: rtl/store_narrow_pkg.sv
// Shared definitions for the store narrowing path: mode codes, FSM encoding
// and the 16-bit representability check that the load side also uses.
package store_pkg;

  localparam logic MODE_HALF = 1'b0;
  localparam logic MODE_WORD = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t BEAT0 = 2'd1;
  localparam state_t BEAT1 = 2'd2;

  // True when sign-extending the low halfword reproduces the full word.
  function automatic logic fits_s16(input logic [31:0] data32);
    return data32 == {{16{data32[15]}}, data32[15:0]};
  endfunction

endpackage

// File: rtl/store_narrow_if.sv
// Request side (32-bit stores) and beat side (16-bit port) of store_narrow,
// plus the overflow status/clear pair.
interface store_narrow_if #(parameter int AW = 16);

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_mode;
  logic [AW-1:0] in_addr;

  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          out_ovf;

  logic          ovf_sticky;
  logic          ovf_clr;

  modport master (
    output in_valid, in_data, in_mode, in_addr, out_ready, ovf_clr,
    input  in_ready, out_valid, out_data, out_addr, out_last, out_ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_addr, out_ready, ovf_clr,
    output in_ready, out_valid, out_data, out_addr, out_last, out_ovf, ovf_sticky
  );

endinterface

// File: rtl/store_narrow.sv
// Splits 32-bit store requests into 16-bit port beats: one beat for a
// halfword store (with overflow flag), two consecutive-address beats for a word.
module store_narrow
  import store_pkg::*;
#(
  parameter bit HI_FIRST = 1'b0,
  parameter int AW       = 16
) (
  input logic           clk,
  input logic           rst_n,
  store_narrow_if.slave bus
);

  state_t        state_q, state_d;
  logic [31:0]   data_q, data_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ovf_q, ovf_d;
  logic          sticky_q, sticky_d;

  logic          out_valid, out_last, out_ovf, second, hi_sel;
  logic [15:0]   out_data;
  logic [AW-1:0] out_addr;
  logic          in_ready, in_acc, out_acc;

  // Beat fields are decoded from the held request, so they stay stable under back-pressure.
  always_comb begin
    out_valid = (state_q != IDLE);
    second    = (state_q == BEAT1);
    out_last  = out_valid && ((mode_q == MODE_HALF) || second);
    out_ovf   = out_valid && ovf_q;
    hi_sel    = (mode_q == MODE_WORD) && (second ^ HI_FIRST);
    out_data  = hi_sel ? data_q[31:16] : data_q[15:0];
    out_addr  = second ? addr_q + AW'(1) : addr_q;
    out_acc   = out_valid && bus.out_ready;
    in_ready  = (state_q == IDLE) || (out_acc && out_last);
    in_acc    = bus.in_valid && in_ready;
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;

    if (in_acc) begin
      state_d = BEAT0;
      data_d  = bus.in_data;
      mode_d  = bus.in_mode;
      addr_d  = bus.in_addr;
      ovf_d   = (bus.in_mode == MODE_HALF) && !fits_s16(bus.in_data);
    end else if (out_acc) begin
      state_d = out_last ? IDLE : BEAT1;
    end

    // A flagged beat being accepted beats a simultaneous clear.
    if (out_acc && out_ovf) begin
      sticky_d = 1'b1;
    end else if (bus.ovf_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      mode_q   <= MODE_HALF;
      addr_q   <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_addr   = out_addr;
  assign bus.out_last   = out_last;
  assign bus.out_ovf    = out_ovf;
  assign bus.ovf_sticky = sticky_q;

endmodule
